// File: rtl/ysyx_22050710_mem_stage_hs.sv
// Memory stage with a valid/ready data-memory port and a 3-state load FSM.
// Optional MS->DS bypass ports: define YSYX_22050710_MS_FWD_EN.
module ysyx_22050710_mem_stage_hs #(
  parameter int WORD_WD         = 64,
  parameter int ADDR_WD         = 32,
  parameter int GPR_ADDR_WD     = 5,
  parameter int CSR_ADDR_WD     = 12,
  parameter int ES_TO_MS_BUS_WD = GPR_ADDR_WD + CSR_ADDR_WD + 7 + 3 * WORD_WD,
  parameter int MS_TO_WS_BUS_WD = 2 + GPR_ADDR_WD + CSR_ADDR_WD + 2 * WORD_WD
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ws_allowin,
  output logic                       o_ms_allowin,
  input  logic                       i_es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
  output logic                       o_ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
  output logic                       o_dmem_req_valid,
  input  logic                       i_dmem_req_ready,
  output logic [ADDR_WD-1:0]         o_dmem_req_addr,
  input  logic                       i_dmem_resp_valid,
  input  logic [WORD_WD-1:0]         i_dmem_resp_data,
  output logic                       o_dmem_resp_ready,
`ifdef YSYX_22050710_MS_FWD_EN
  output logic                       o_ms_fwd_valid,
  output logic [WORD_WD-1:0]         o_ms_fwd_data,
`endif
  output logic [GPR_ADDR_WD-1:0]     o_ms_to_ds_gpr_rd,
  output logic [CSR_ADDR_WD-1:0]     o_ms_to_ds_csr_rd
);

  localparam int BYTES = WORD_WD / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam bit IS64  = (WORD_WD == 64);
  localparam logic [ADDR_WD-1:0] ALIGN_MASK = ~ADDR_WD'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                     state;
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;
  logic [WORD_WD-1:0]         load_data;

  logic [GPR_ADDR_WD-1:0] rd;
  logic [CSR_ADDR_WD-1:0] csr;
  logic                   gpr_wen;
  logic                   csr_wen;
  logic                   mem_ren;
  logic [2:0]             mem_op;
  logic                   csr_inst_sel;
  logic [WORD_WD-1:0]     csrrdata;
  logic [WORD_WD-1:0]     alu_result;
  logic [WORD_WD-1:0]     csr_result;

  assign {rd, csr, gpr_wen, csr_wen, mem_ren, mem_op,
          csr_inst_sel, csrrdata, alu_result, csr_result} = bus_q;

  logic               ready_go;
  logic               allowin;
  logic [WORD_WD-1:0] gpr_result;
  logic [OFF_W-1:0]   offset;
  logic [WORD_WD-1:0] shifted;
  logic [WORD_WD-1:0] ext;

  assign ready_go = !mem_ren || (state == S_DONE);
  assign allowin  = !ms_valid || (ready_go && i_ws_allowin);

  // Pipeline valid and payload latch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ms_valid <= 1'b0;
      bus_q    <= '0;
    end else if (allowin) begin
      ms_valid <= i_es_to_ms_valid;
      bus_q    <= i_es_to_ms_bus;
    end
  end

  // Load FSM: issue request, wait for response, hold result until WS takes it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      load_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ms_valid && mem_ren && i_dmem_req_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_dmem_resp_valid) begin
            load_data <= ext;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ws_allowin)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign offset  = alu_result[OFF_W-1:0];
  assign shifted = i_dmem_resp_data >> {offset, 3'b000};

  // Byte/half/word/dword select with sign or zero extension
  always_comb begin
    ext = '0;
    unique case (mem_op)
      3'b000:  ext = WORD_WD'($signed(shifted[7:0]));
      3'b001:  ext = WORD_WD'($signed(shifted[15:0]));
      3'b010:  ext = WORD_WD'($signed(shifted[31:0]));
      3'b011:  ext = IS64 ? shifted : '0;
      3'b100:  ext = WORD_WD'(shifted[7:0]);
      3'b101:  ext = WORD_WD'(shifted[15:0]);
      3'b110:  ext = WORD_WD'(shifted[31:0]);
      default: ext = '0;
    endcase
  end

  assign gpr_result = mem_ren      ? load_data :
                      csr_inst_sel ? csrrdata  : alu_result;

  assign o_ms_allowin      = allowin;
  assign o_ms_to_ws_valid  = ms_valid && ready_go;
  assign o_ms_to_ws_bus    = {gpr_wen, rd, gpr_result,
                              csr_wen, csr, csr_result};
  assign o_dmem_req_valid  = (state == S_IDLE) && ms_valid && mem_ren;
  assign o_dmem_req_addr   = alu_result[ADDR_WD-1:0] & ALIGN_MASK;
  assign o_dmem_resp_ready = (state == S_WAIT);
  assign o_ms_to_ds_gpr_rd = (ms_valid && gpr_wen) ? rd : '0;
  assign o_ms_to_ds_csr_rd = (ms_valid && csr_wen) ? csr : '0;

`ifdef YSYX_22050710_MS_FWD_EN
  assign o_ms_fwd_valid = ms_valid && gpr_wen && ready_go;
  assign o_ms_fwd_data  = gpr_result;
`endif

endmodule
